// File: rtl/fifo_ctrl_16_8_if.sv
// fifo_ctrl_16_8_if: client push/pop handshake plus RAM-side signals; master = client/RAM side, slave = controller
interface fifo_ctrl_16_8_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              flush;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_accept;
  logic              pop;
  logic              pop_accept;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ram_write;
  logic [ADDR_W-1:0] ram_wr_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_read;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [DATA_W-1:0] ram_data_out;
`ifdef FIFO_CTRL_ERR_EN
  logic              overflow;
  logic              underflow;
  modport master (
    output flush, push, push_data, pop, ram_data_out,
    input  push_accept, pop_accept, pop_valid, pop_data, full, empty, count,
    input  ram_write, ram_wr_addr, ram_data_in, ram_read, ram_rd_addr, overflow, underflow
  );
  modport slave (
    input  flush, push, push_data, pop, ram_data_out,
    output push_accept, pop_accept, pop_valid, pop_data, full, empty, count,
    output ram_write, ram_wr_addr, ram_data_in, ram_read, ram_rd_addr, overflow, underflow
  );
`else
  modport master (
    output flush, push, push_data, pop, ram_data_out,
    input  push_accept, pop_accept, pop_valid, pop_data, full, empty, count,
    input  ram_write, ram_wr_addr, ram_data_in, ram_read, ram_rd_addr
  );
  modport slave (
    input  flush, push, push_data, pop, ram_data_out,
    output push_accept, pop_accept, pop_valid, pop_data, full, empty, count,
    output ram_write, ram_wr_addr, ram_data_in, ram_read, ram_rd_addr
  );
`endif
endinterface

// File: rtl/fifo_ctrl_16_8.sv
// fifo_ctrl_16_8: pointer/status/read-pipeline controller turning external dual_ram_16_8 into a FIFO
// Optional FIFO_CTRL_ERR_EN adds sticky overflow/underflow flags.
module fifo_ctrl_16_8 #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic             clk,
  input logic             reset_n,
  fifo_ctrl_16_8_if.slave bus
);
  logic [ADDR_W:0]   wptr_q, wptr_d, rptr_q, rptr_d, count;
  logic              pop_valid_q, pop_valid_d;
  logic              full, empty, push_accept, pop_accept;
  logic [DATA_W-1:0] wr_data, rd_data;
  always_comb begin
    count       = wptr_q - rptr_q;
    empty       = wptr_q == rptr_q;
    full        = count == (ADDR_W+1)'(DEPTH);
    push_accept = reset_n && bus.push && !full && !bus.flush;
    pop_accept  = reset_n && bus.pop && !empty && !bus.flush;
    wptr_d      = bus.flush ? '0 : wptr_q + (ADDR_W+1)'(push_accept);
    rptr_d      = bus.flush ? '0 : rptr_q + (ADDR_W+1)'(pop_accept);
    pop_valid_d = pop_accept;
    wr_data     = bus.push_data;
    rd_data     = bus.ram_data_out;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      pop_valid_q <= pop_valid_d;
    end
  assign bus.push_accept = push_accept;
  assign bus.pop_accept  = pop_accept;
  assign bus.pop_valid   = pop_valid_q;
  assign bus.pop_data    = rd_data;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.count       = count;
  assign bus.ram_write   = push_accept;
  assign bus.ram_wr_addr = wptr_q[ADDR_W-1:0];
  assign bus.ram_data_in = wr_data;
  assign bus.ram_read    = pop_accept;
  assign bus.ram_rd_addr = rptr_q[ADDR_W-1:0];
`ifdef FIFO_CTRL_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;
  always_comb begin
    overflow_d  = !bus.flush && (overflow_q || (bus.push && full));
    underflow_d = !bus.flush && (underflow_q || (bus.pop && empty));
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule
